// File: rtl/climate_ctrl_param.sv
// Incubator climate controller: debounced heat/idle/cool mode FSM with dwell lockout and N-level cooler speed.
// Optional build macro OVERTEMP_ALARM_EN adds ALARM_TH and overtemp_alarm_o, forcing full cooling while set.
module climate_ctrl_param #(
    parameter int TEMP_W     = 8,
    parameter int LEVELS     = 3,
    parameter int SPEED_W    = 4,
    parameter int HEAT_ON    = 15,
    parameter int HEAT_OFF   = 30,
    parameter int COOL_ON    = 35,
    parameter int COOL_OFF   = 25,
    parameter int STEP       = 5,
    parameter int SPEED_BASE = 4,
    parameter int SPEED_INC  = 2,
    parameter int DEBOUNCE   = 4,
    parameter int MIN_DWELL  = 16
`ifdef OVERTEMP_ALARM_EN
    ,
    parameter int ALARM_TH   = 50
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [TEMP_W-1:0]  temperature_i,
    input  logic                      temp_valid_i,
    output logic                      heater_on_o,
    output logic                      cooler_on_o,
    output logic [SPEED_W-1:0]        cooler_speed_o,
    output logic [1:0]                mode_o,
    output logic [2:0]                level_o
`ifdef OVERTEMP_ALARM_EN
    ,
    output logic                      overtemp_alarm_o
`endif
);

    // state     | meaning
    // MODE_IDLE | neither heating nor cooling
    // MODE_COOL | fan running at level_q (1..LEVELS)
    // MODE_HEAT | heater on
    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_COOL = 2'b01,
        MODE_HEAT = 2'b10
    } mode_e;

    typedef enum logic [2:0] {
        C_NONE,
        C_TO_COOL,
        C_TO_HEAT,
        C_TO_IDLE,
        C_UP,
        C_DOWN
    } cand_e;

    // Debounce counter must hold DEBOUNCE+1 for the saturate-then-release case.
    localparam int DEB_W   = $clog2(DEBOUNCE + 2);
    localparam int DWELL_W = $clog2(MIN_DWELL + 2);
    localparam int SPD_MAX = (1 << SPEED_W) - 1;

    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE);
    localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(MIN_DWELL);
    localparam logic [2:0]         LEV_TOP    = 3'(LEVELS);

    localparam logic signed [TEMP_W-1:0] TH_HEAT_ON  = TEMP_W'(HEAT_ON);
    localparam logic signed [TEMP_W-1:0] TH_HEAT_OFF = TEMP_W'(HEAT_OFF);
    localparam logic signed [TEMP_W-1:0] TH_COOL_ON  = TEMP_W'(COOL_ON);
    localparam logic signed [TEMP_W-1:0] TH_COOL_OFF = TEMP_W'(COOL_OFF);

    function automatic logic signed [TEMP_W-1:0] thr(input int v);
        return TEMP_W'(v);
    endfunction

    function automatic logic [SPEED_W-1:0] speed_of(input logic [2:0] lv);
        int s;
        if (lv == 3'd0) return '0;
        s = SPEED_BASE + (int'(lv) - 1) * SPEED_INC;
        if (s > SPD_MAX) s = SPD_MAX;
        if (s < 0) s = 0;
        return SPEED_W'(s);
    endfunction

    mode_e               mode_q, mode_d;
    logic [2:0]          level_q, level_d;
    logic [DEB_W-1:0]    deb_q, deb_d;
    cand_e               cand_q, cand_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                heater_q, cooler_q;
    logic [SPEED_W-1:0]  speed_q;

    cand_e                     cand;
    logic signed [TEMP_W-1:0]  up_th, dn_th;
    logic                      is_mode_cand;
    logic                      blocked;
    logic                      fire;
    logic                      normal_en;
    logic [DEB_W-1:0]          n_cnt;

`ifdef OVERTEMP_ALARM_EN
    localparam logic signed [TEMP_W-1:0] TH_ALARM_SET = TEMP_W'(ALARM_TH);
    localparam logic signed [TEMP_W-1:0] TH_ALARM_CLR = TEMP_W'(ALARM_TH - STEP);

    logic              alarm_q, alarm_d;
    logic [DEB_W-1:0]  acnt_q, acnt_d;
    logic              acond;
    logic [DEB_W-1:0]  an_cnt;
`endif

    always_comb begin
        cand  = C_NONE;
        up_th = thr(COOL_ON + int'(level_q) * STEP);
        dn_th = thr(COOL_ON + (int'(level_q) - 2) * STEP);

        // Mode candidates are tested first so they win over level steps.
        case (mode_q)
            MODE_IDLE: begin
                if (temperature_i > TH_COOL_ON)      cand = C_TO_COOL;
                else if (temperature_i < TH_HEAT_ON) cand = C_TO_HEAT;
            end
            MODE_HEAT: begin
                if (temperature_i > TH_HEAT_OFF) cand = C_TO_IDLE;
            end
            MODE_COOL: begin
                if (level_q == 3'd1 && temperature_i < TH_COOL_OFF)   cand = C_TO_IDLE;
                else if (level_q < LEV_TOP && temperature_i > up_th)  cand = C_UP;
                else if (level_q > 3'd1 && temperature_i < dn_th)     cand = C_DOWN;
            end
            default: cand = C_NONE;
        endcase

        is_mode_cand = (cand == C_TO_COOL) || (cand == C_TO_HEAT) || (cand == C_TO_IDLE);
        blocked      = is_mode_cand && (dwell_q != '0);
        n_cnt        = (cand == cand_q && deb_q != '0) ? deb_q + 1'b1 : DEB_W'(1);
        fire         = temp_valid_i && (cand != C_NONE) && !blocked && (n_cnt >= DEB_MAX);

        mode_d  = mode_q;
        level_d = level_q;
        deb_d   = deb_q;
        cand_d  = cand_q;
        dwell_d = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

`ifdef OVERTEMP_ALARM_EN
        alarm_d = alarm_q;
        acnt_d  = acnt_q;
        acond   = alarm_q ? (temperature_i < TH_ALARM_CLR) : (temperature_i > TH_ALARM_SET);
        an_cnt  = acnt_q + 1'b1;
        if (temp_valid_i) begin
            if (!acond) begin
                acnt_d = '0;
            end else if (an_cnt >= DEB_MAX) begin
                acnt_d  = '0;
                alarm_d = !alarm_q;
            end else begin
                acnt_d = an_cnt;
            end
        end
        normal_en = !alarm_q;
`else
        normal_en = 1'b1;
`endif

        if (temp_valid_i && normal_en) begin
            if (cand == C_NONE) begin
                deb_d  = '0;
                cand_d = C_NONE;
            end else if (fire) begin
                deb_d  = '0;
                cand_d = C_NONE;
                case (cand)
                    C_TO_COOL: begin
                        mode_d  = MODE_COOL;
                        level_d = 3'd1;
                    end
                    C_TO_HEAT: begin
                        mode_d  = MODE_HEAT;
                        level_d = 3'd0;
                    end
                    C_TO_IDLE: begin
                        mode_d  = MODE_IDLE;
                        level_d = 3'd0;
                    end
                    C_UP:      level_d = level_q + 3'd1;
                    C_DOWN:    level_d = level_q - 3'd1;
                    default:   level_d = level_q;
                endcase
            end else begin
                deb_d  = (blocked && n_cnt > DEB_MAX) ? DEB_MAX : n_cnt;
                cand_d = cand;
            end
        end

`ifdef OVERTEMP_ALARM_EN
        // Alarm overrides the normal FSM and ignores dwell.
        if (alarm_d) begin
            mode_d  = MODE_COOL;
            level_d = LEV_TOP;
            deb_d   = '0;
            cand_d  = C_NONE;
        end
`endif

        if (mode_d != mode_q) dwell_d = DWELL_INIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= MODE_IDLE;
            level_q  <= '0;
            deb_q    <= '0;
            cand_q   <= C_NONE;
            dwell_q  <= DWELL_INIT;
            heater_q <= 1'b0;
            cooler_q <= 1'b0;
            speed_q  <= '0;
        end else begin
            mode_q   <= mode_d;
            level_q  <= level_d;
            deb_q    <= deb_d;
            cand_q   <= cand_d;
            dwell_q  <= dwell_d;
            heater_q <= (mode_d == MODE_HEAT);
            cooler_q <= (mode_d == MODE_COOL);
            speed_q  <= speed_of(level_d);
        end
    end

`ifdef OVERTEMP_ALARM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_q <= 1'b0;
            acnt_q  <= '0;
        end else begin
            alarm_q <= alarm_d;
            acnt_q  <= acnt_d;
        end
    end

    assign overtemp_alarm_o = alarm_q;
`endif

    assign heater_on_o    = heater_q;
    assign cooler_on_o    = cooler_q;
    assign cooler_speed_o = speed_q;
    assign mode_o         = mode_q;
    assign level_o        = level_q;

endmodule

// File: tb/tb_climate_ctrl_param.sv
// Self-checking bench for climate_ctrl_param: directed plan steps plus randomized stimulus vs. a behavioural model.
module tb_climate_ctrl_param;
    localparam int TEMP_W = 8, LEVELS = 3, SPEED_W = 4;
    localparam int HEAT_ON = 15, HEAT_OFF = 30, COOL_ON = 35, COOL_OFF = 25, STEP = 5;
    localparam int SPEED_BASE = 4, SPEED_INC = 2, DEB = 4, MIN_DWELL = 16, ALARM_TH = 50;

    logic                     clk = 1'b0;
    logic                     reset;
    logic signed [TEMP_W-1:0] temperature;
    logic                     temp_valid;
    logic                     heater_on, cooler_on;
    logic [SPEED_W-1:0]       cooler_speed;
    logic [1:0]               mode;
    logic [2:0]               level;
    logic                     overtemp_alarm;

    climate_ctrl_param #(
        .TEMP_W(TEMP_W), .LEVELS(LEVELS), .SPEED_W(SPEED_W),
        .HEAT_ON(HEAT_ON), .HEAT_OFF(HEAT_OFF), .COOL_ON(COOL_ON), .COOL_OFF(COOL_OFF),
        .STEP(STEP), .SPEED_BASE(SPEED_BASE), .SPEED_INC(SPEED_INC),
        .DEBOUNCE(DEB), .MIN_DWELL(MIN_DWELL)
`ifdef OVERTEMP_ALARM_EN
        , .ALARM_TH(ALARM_TH)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .temperature_i(temperature),
        .temp_valid_i(temp_valid),
        .heater_on_o(heater_on),
        .cooler_on_o(cooler_on),
        .cooler_speed_o(cooler_speed),
        .mode_o(mode),
        .level_o(level)
`ifdef OVERTEMP_ALARM_EN
        , .overtemp_alarm_o(overtemp_alarm)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    // Model: mode 0 idle / 1 cool / 2 heat; candidate 0 none, 1 cool, 2 heat, 3 idle, 4 up, 5 down.
    int m_mode, m_lvl, m_run, m_cand, m_since, a_set, a_run;

    function automatic int exp_speed(input int lv);
        int s;
        if (lv == 0) return 0;
        s = SPEED_BASE + (lv - 1) * SPEED_INC;
        return (s > (1 << SPEED_W) - 1) ? (1 << SPEED_W) - 1 : s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int t, input bit v, input bit r);
        int c, prev_mode, was_alarm;
        if (r) begin
            m_mode = 0; m_lvl = 0; m_run = 0; m_cand = 0; m_since = 0; a_set = 0; a_run = 0;
            return;
        end
        prev_mode = m_mode;
        was_alarm = a_set;
        if (v) begin
`ifdef OVERTEMP_ALARM_EN
            if (a_set ? (t < ALARM_TH - STEP) : (t > ALARM_TH)) a_run++;
            else a_run = 0;
            if (a_run >= DEB) begin
                a_set = !a_set;
                a_run = 0;
            end
`endif
            if (!was_alarm) begin
                c = 0;
                if (m_mode == 0) c = (t > COOL_ON) ? 1 : (t < HEAT_ON) ? 2 : 0;
                else if (m_mode == 2) c = (t > HEAT_OFF) ? 3 : 0;
                else if (m_lvl == 1 && t < COOL_OFF) c = 3;
                else if (m_lvl < LEVELS && t > COOL_ON + m_lvl * STEP) c = 4;
                else if (m_lvl > 1 && t < COOL_ON + (m_lvl - 2) * STEP) c = 5;
                if (c == 0) m_run = 0;
                else m_run = (c == m_cand && m_run > 0) ? m_run + 1 : 1;
                m_cand = c;
                if (c != 0 && m_run >= DEB && !(c <= 3 && m_since < MIN_DWELL)) begin
                    m_run = 0;
                    case (c)
                        1: begin m_mode = 1; m_lvl = 1; end
                        2: begin m_mode = 2; m_lvl = 0; end
                        3: begin m_mode = 0; m_lvl = 0; end
                        4: m_lvl++;
                        default: m_lvl--;
                    endcase
                end
            end
            if (a_set != 0) begin
                m_mode = 1; m_lvl = LEVELS; m_run = 0; m_cand = 0;
            end
        end
        if (m_mode != prev_mode) m_since = 0;
        else if (m_since < 100000) m_since++;
    endtask

    task automatic cyc(input int t, input bit v, input bit r);
        temperature = TEMP_W'(t);
        temp_valid  = v;
        reset       = r;
        @(posedge clk);
        model_edge(t, v, r);
        @(negedge clk);
    endtask

    task automatic hold(input int t, input int n);
        for (int i = 0; i < n; i++) cyc(t, 1'b1, 1'b0);
    endtask

    task automatic expect_out(input string tag, input int md, input int lv, input int sp);
        check({tag, ".mode"}, int'(mode), md);
        check({tag, ".level"}, int'(level), lv);
        check({tag, ".speed"}, int'(cooler_speed), sp);
        check({tag, ".heater"}, int'(heater_on), (md == 2) ? 1 : 0);
        check({tag, ".cooler"}, int'(cooler_on), (md == 1) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc.mode", int'(mode), m_mode);
            check("cyc.level", int'(level), m_lvl);
            check("cyc.speed", int'(cooler_speed), exp_speed(m_lvl));
            check("cyc.heater", int'(heater_on), (m_mode == 2) ? 1 : 0);
            check("cyc.cooler", int'(cooler_on), (m_mode == 1) ? 1 : 0);
`ifdef OVERTEMP_ALARM_EN
            check("cyc.alarm", int'(overtemp_alarm), a_set);
`endif
        end
    end

    initial begin
        int t, len;
        bit v, r;
        reset = 1'b1; temperature = '0; temp_valid = 1'b0;
        cyc(0, 1'b0, 1'b1);
        cyc(0, 1'b0, 1'b1);
        chk_en = 1;
        expect_out("reset", 0, 0, 0);

        hold(20, 40);
        expect_out("idle20", 0, 0, 0);

        hold(36, 3);
        hold(30, 1);
        expect_out("short36", 0, 0, 0);
        hold(30, 2);

        hold(36, 3);
        expect_out("cool_pre", 0, 0, 0);
        hold(36, 1);
        expect_out("cool_l1", 1, 1, 4);

        hold(41, 4);
        expect_out("cool_l2", 1, 2, 6);
        hold(46, 4);
        expect_out("cool_l3", 1, 3, 8);
        hold(39, 4);
        expect_out("down_l2", 1, 2, 6);
        hold(24, 4);
        expect_out("down_l1", 1, 1, 4);
        hold(24, 8);
        expect_out("cool_idle", 0, 0, 0);

        hold(20, 20);
        hold(10, 3);
        expect_out("heat_pre", 0, 0, 0);
        hold(10, 1);
        expect_out("heat", 2, 0, 0);
        hold(10, 4);
        hold(31, 11);
        expect_out("heat_dwell", 2, 0, 0);
        hold(31, 2);
        expect_out("heat_idle", 0, 0, 0);

        hold(20, 20);
        for (int i = 0; i < 3; i++) begin
            cyc(36, 1'b1, 1'b0);
            cyc(36, 1'b0, 1'b0);
        end
        expect_out("tog_pre", 0, 0, 0);
        cyc(36, 1'b1, 1'b0);
        expect_out("tog_cool", 1, 1, 4);

        hold(42, 2);
        cyc(42, 1'b1, 1'b1);
        expect_out("mid_reset", 0, 0, 0);
        hold(42, 3);
        expect_out("post_reset", 0, 0, 0);

`ifdef OVERTEMP_ALARM_EN
        hold(20, 20);
        hold(10, 4);
        expect_out("al_heat", 2, 0, 0);
        hold(55, 3);
        check("al_pre", int'(overtemp_alarm), 0);
        hold(55, 1);
        check("al_set", int'(overtemp_alarm), 1);
        expect_out("al_cool", 1, 3, 8);
        hold(40, 3);
        check("al_hold", int'(overtemp_alarm), 1);
        hold(40, 1);
        check("al_clr", int'(overtemp_alarm), 0);
        expect_out("al_after", 1, 3, 8);
`endif

        for (int seg = 0; seg < 400; seg++) begin
            t   = int'($urandom_range(0, 80)) - 20;
            len = int'($urandom_range(1, 10));
            for (int k = 0; k < len; k++) begin
                v = ($urandom_range(0, 99) < 85);
                r = ($urandom_range(0, 599) == 0);
                cyc(t, v, r);
            end
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
